// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg
// Shared definitions for the UART transmit feeder: launch FSM state
// encodings and the default FIFO geometry.
package uart_tx_feeder_pkg;

  // Launch FSM states. All four 2-bit codes are used, but the FSM still
  // has a default branch that recovers to FEED_IDLE.
  typedef enum logic [1:0] {
    FEED_IDLE      = 2'd0,
    FEED_LAUNCH    = 2'd1,
    FEED_WAIT_BUSY = 2'd2,
    FEED_WAIT_DONE = 2'd3
  } feed_state_t;

  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_ADDR_W = 4;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// sync_fifo
// Single-clock byte FIFO with registered occupancy and flags.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, din      : write request and data (ignored while full)
//   pop, dout      : read request and data (dout shows mem[rd_ptr])
//   full, empty    : registered flags, reflect the previous edge
//   count          : registered occupancy, 0..DEPTH
module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [7:0]        mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              do_push;
  logic              do_pop;

  // Gating on the registered flags keeps a full FIFO from being rescued
  // by a same-cycle pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Buffers CPU-stored bytes and launches them one at a time into the UART
// transmitter via a one-cycle wr_en pulse, waiting for txBusy to rise and
// fall between bytes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_data    : byte from the CPU store path
//   wr_req     : push request, one byte per cycle
//   clr_ovf    : clears the sticky overflow flag
//   tx_busy    : transmitter busy
//   tx_data    : byte to transmit, held from one pop to the next
//   tx_wr_en   : one-cycle launch pulse
//   full/empty : FIFO flags
//   count      : FIFO occupancy, 0..DEPTH
//   overflow   : sticky, a push was dropped because the FIFO was full
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      wr_data,
  input  logic            wr_req,
  input  logic            clr_ovf,
  input  logic            tx_busy,
  output logic [7:0]      tx_data,
  output logic            tx_wr_en,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow
);

  feed_state_t state;
  feed_state_t state_next;
  logic        pop;
  logic        wr_en_next;
  logic [7:0]  fifo_dout;
  logic        drop;

  assign drop = wr_req & full;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_req),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Next-state logic. A pop only happens from FEED_IDLE with the
  // transmitter idle, which is what keeps a launch from ever overlapping
  // a busy transmitter, including right after a reset of this block.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    wr_en_next = 1'b0;
    case (state)
      FEED_IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          wr_en_next = 1'b1;
          state_next = FEED_LAUNCH;
        end
      end
      FEED_LAUNCH:    state_next = FEED_WAIT_BUSY;
      FEED_WAIT_BUSY: if (tx_busy)  state_next = FEED_WAIT_DONE;
      FEED_WAIT_DONE: if (!tx_busy) state_next = FEED_IDLE;
      default:        state_next = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FEED_IDLE;
      tx_wr_en <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_next;
      tx_wr_en <= wr_en_next;
      if (pop) tx_data <= fifo_dout;
    end
  end

  // A dropped push in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// Directed bench with a small transmitter model. Accepted pushes enter an
// expected-byte queue; a monitor pops and compares on every tx_wr_en pulse.
module tb_uart_tx_feeder;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int BUSY_LEN = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      wr_data;
  logic            wr_req;
  logic            clr_ovf;
  logic            tx_busy;
  logic [7:0]      tx_data;
  logic            tx_wr_en;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;

  logic model_busy = 1'b0;
  int   model_cnt  = 0;
  logic hold_busy  = 1'b0;
  logic prev_wr_en = 1'b0;

  logic [7:0] exp_q [$];
  int tests    = 0;
  int fails    = 0;
  int launches = 0;

  assign tx_busy = model_busy | hold_busy;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_req   (wr_req),
    .clr_ovf  (clr_ovf),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_wr_en (tx_wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // Transmitter model: samples wr_en at the closing edge, then stays busy
  // for BUSY_LEN cycles. It has no reset, like the real transmitter.
  always @(posedge clk) begin
    if (model_busy) begin
      if (model_cnt <= 1) model_busy <= 1'b0;
      model_cnt <= model_cnt - 1;
    end else if (tx_wr_en) begin
      model_busy <= 1'b1;
      model_cnt  <= BUSY_LEN;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Launch monitor.
  always @(negedge clk) begin
    if (rst_n && tx_wr_en) begin
      launches++;
      checkOutput("launch_while_idle", 32'(tx_busy), 0);
      checkOutput("pulse_width", 32'(prev_wr_en), 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_launch: got 0x%0h, expected no launch at %0t", tx_data, $time);
      end else begin
        checkOutput("launch_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    prev_wr_en = tx_wr_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [7:0] data, input logic clr);
    wr_req  = req;
    wr_data = data;
    clr_ovf = clr;
    tick();
  endtask

  task automatic pushByte(input logic [7:0] data, input bit accepted);
    if (accepted) exp_q.push_back(data);
    applyStimulus(1'b1, data, 1'b0);
  endtask

  task automatic waitBusy(input logic value, input string name);
    int n = 0;
    while (tx_busy !== value && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: tx_busy stuck at %0b, expected %0b", name, tx_busy, value);
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy || !empty) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: drain timeout, %0d bytes still expected", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    rst_n   = 1'b0;
    wr_req  = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    repeat (2) tick();
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    checkOutput("rst_tx_wr_en", 32'(tx_wr_en), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // Single byte: cycle 0 push, cycle 1 count=1, cycle 2 pulse, cycle 3 busy.
    base = launches;
    pushByte(8'hA5, 1'b1);
    wr_req = 1'b0;
    checkOutput("single_count_c1", 32'(count), 1);
    checkOutput("single_wr_en_c1", 32'(tx_wr_en), 0);
    tick();
    checkOutput("single_wr_en_c2", 32'(tx_wr_en), 1);
    checkOutput("single_data_c2", 32'(tx_data), 'hA5);
    checkOutput("single_count_c2", 32'(count), 0);
    tick();
    checkOutput("single_wr_en_c3", 32'(tx_wr_en), 0);
    checkOutput("single_busy_c3", 32'(tx_busy), 1);
    waitDrain("single");
    checkOutput("single_launches", 32'(launches - base), 1);

    // Burst of 16 consecutive bytes.
    base = launches;
    for (int i = 1; i <= 16; i++) pushByte(8'(i), 1'b1);
    wr_req = 1'b0;
    waitDrain("burst");
    checkOutput("burst_launches", 32'(launches - base), 16);
    checkOutput("burst_overflow", 32'(overflow), 0);

    // Overflow with the transmitter held busy.
    base = launches;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) pushByte(8'(8'h20 + i), 1'b1);
    checkOutput("ovf_full", 32'(full), 1);
    checkOutput("ovf_count16", 32'(count), 16);
    checkOutput("ovf_flag_before", 32'(overflow), 0);
    pushByte(8'hEE, 1'b0);
    wr_req = 1'b0;
    checkOutput("ovf_flag_set", 32'(overflow), 1);
    checkOutput("ovf_count_kept", 32'(count), 16);
    applyStimulus(1'b0, 8'h00, 1'b1);
    clr_ovf = 1'b0;
    checkOutput("ovf_cleared", 32'(overflow), 0);
    hold_busy = 1'b0;
    waitDrain("overflow");
    checkOutput("ovf_launches", 32'(launches - base), 16);

    // Simultaneous push and pop at count 5, 40 bytes through the pointers.
    base = launches;
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) pushByte(8'(8'h40 + i), 1'b1);
    wr_req = 1'b0;
    checkOutput("pp_count_start", 32'(count), 5);
    hold_busy = 1'b0;
    pushByte(8'h45, 1'b1);
    wr_req = 1'b0;
    checkOutput("pp_count_first", 32'(count), 5);
    checkOutput("pp_wr_en_first", 32'(tx_wr_en), 1);
    for (int r = 0; r < 34; r++) begin
      waitBusy(1'b1, "pp_busy_rise");
      waitBusy(1'b0, "pp_busy_fall");
      tick();
      pushByte(8'(8'h46 + r), 1'b1);
      wr_req = 1'b0;
      checkOutput("pp_count", 32'(count), 5);
      checkOutput("pp_wr_en", 32'(tx_wr_en), 1);
    end
    waitDrain("push_pop");
    checkOutput("pp_launches", 32'(launches - base), 40);

    // Reset while the transmitter is busy and three bytes are queued.
    for (int i = 0; i < 4; i++) pushByte(8'(8'h90 + i), 1'b1);
    wr_req = 1'b0;
    checkOutput("rm_count3", 32'(count), 3);
    checkOutput("rm_busy", 32'(tx_busy), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("rm_tx_data", 32'(tx_data), 0);
    checkOutput("rm_tx_wr_en", 32'(tx_wr_en), 0);
    checkOutput("rm_count", 32'(count), 0);
    checkOutput("rm_empty", 32'(empty), 1);
    checkOutput("rm_full", 32'(full), 0);
    checkOutput("rm_overflow", 32'(overflow), 0);
    tick();
    rst_n = 1'b1;
    checkOutput("rm_still_busy", 32'(tx_busy), 1);
    base = launches;
    while (tx_busy) begin
      checkOutput("rm_no_launch", 32'(tx_wr_en), 0);
      tick();
    end
    pushByte(8'hC3, 1'b1);
    wr_req = 1'b0;
    waitDrain("after_reset");
    checkOutput("rm_launches", 32'(launches - base), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
